// File: rtl/alu_cond_writeback_pkg.sv
// Shared ARM condition codes and default widths for the ALU writeback stage.
package alu_cond_writeback_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int RD_W_DEF   = 4;
    localparam int CNT_W_DEF  = 16;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_AL = 4'b1110;
endpackage

// File: rtl/alu_cond_writeback_if.sv
// Handshake bus between the ALU (upstream) and the register-file/PC stage (downstream).
interface alu_cond_writeback_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_zflag;
    logic              in_flag_upd;
    logic [3:0]        in_cond;
    logic [RD_W-1:0]   in_rd;
    logic              in_reg_we;
    logic              in_mem_we;
    logic              in_pc_src;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [RD_W-1:0]   out_rd;
    logic              out_reg_we;
    logic              out_mem_we;
    logic              out_pc_src;

    modport slave (
        input  in_valid, in_result, in_zflag, in_flag_upd, in_cond, in_rd,
               in_reg_we, in_mem_we, in_pc_src, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_reg_we, out_mem_we, out_pc_src
    );

    modport master (
        output in_valid, in_result, in_zflag, in_flag_upd, in_cond, in_rd,
               in_reg_we, in_mem_we, in_pc_src, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_reg_we, out_mem_we, out_pc_src
    );
endinterface

// File: rtl/alu_cond_writeback_cond_check.sv
// Combinational ARM condition evaluation against the current Z flag.
module cond_check
    import alu_cond_writeback_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       z,
    output logic       pass,
    output logic       illegal
);
    always_comb begin
        pass    = 1'b0;
        illegal = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_AL: pass = 1'b1;
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_cond_writeback.sv
// One-entry writeback register: holds the architectural Z flag, evaluates the
// condition field on accept and gates register/memory/PC write enables.
module alu_cond_writeback
    import alu_cond_writeback_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_cond_writeback_if.slave  bus,
    output logic                 z_flag,
    output logic                 cond_illegal,
    output logic [CNT_W-1:0]     squash_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [RD_W-1:0]   rd;
        logic              reg_we;
        logic              mem_we;
        logic              pc_src;
    } wb_t;

    wb_t  wb_q;
    logic vld_q;
    logic accept;
    logic pass;
    logic illegal;

    // Condition sees the flag as it stands before this instruction updates it.
    cond_check u_cond (
        .cond    (bus.in_cond),
        .z       (z_flag),
        .pass    (pass),
        .illegal (illegal)
    );

    assign bus.in_ready = !vld_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q        <= 1'b0;
            wb_q         <= '0;
            z_flag       <= 1'b0;
            cond_illegal <= 1'b0;
            squash_cnt   <= '0;
        end else begin
            cond_illegal <= accept && illegal;
            if (accept) begin
                vld_q       <= 1'b1;
                wb_q.result <= bus.in_result;
                wb_q.rd     <= bus.in_rd;
                wb_q.reg_we <= pass && bus.in_reg_we;
                wb_q.mem_we <= pass && bus.in_mem_we;
                wb_q.pc_src <= pass && bus.in_pc_src;
                if (pass && bus.in_flag_upd)
                    z_flag <= bus.in_zflag;
                if (!pass && squash_cnt != CNT_MAX)
                    squash_cnt <= squash_cnt + CNT_ONE;
            end else if (bus.out_ready) begin
                // Drained with nothing behind it: data may go stale, enables must not.
                vld_q       <= 1'b0;
                wb_q.reg_we <= 1'b0;
                wb_q.mem_we <= 1'b0;
                wb_q.pc_src <= 1'b0;
            end
        end
    end

    assign bus.out_valid  = vld_q;
    assign bus.out_result = wb_q.result;
    assign bus.out_rd     = wb_q.rd;
    assign bus.out_reg_we = wb_q.reg_we;
    assign bus.out_mem_we = wb_q.mem_we;
    assign bus.out_pc_src = wb_q.pc_src;
endmodule

// File: tb/tb_alu_cond_writeback.sv
// Self-checking bench for alu_cond_writeback: directed scenarios plus randomized traffic vs. a reference model.
module tb_alu_cond_writeback;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             z_flag;
    logic             cond_illegal;
    logic [CNT_W-1:0] squash_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic        m_ov, m_rwe, m_mwe, m_pc, m_z, m_ill;
    logic [31:0] m_res;
    logic [3:0]  m_rd;
    int          m_cnt;

    alu_cond_writeback_if #(.DATA_W(32), .RD_W(4)) bus ();

    alu_cond_writeback #(.DATA_W(32), .RD_W(4), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .z_flag       (z_flag),
        .cond_illegal (cond_illegal),
        .squash_cnt   (squash_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ov = 0; m_rwe = 0; m_mwe = 0; m_pc = 0; m_z = 0; m_ill = 0;
        m_res = 0; m_rd = 0; m_cnt = 0;
    endtask

    task automatic drive(input logic v, input logic [3:0] cond, input logic fu, input logic zin,
                         input logic rwe, input logic mwe, input logic pc,
                         input logic [31:0] res, input logic [3:0] rd, input logic ordy);
        bus.in_valid = v; bus.in_cond = cond; bus.in_flag_upd = fu; bus.in_zflag = zin;
        bus.in_reg_we = rwe; bus.in_mem_we = mwe; bus.in_pc_src = pc;
        bus.in_result = res; bus.in_rd = rd; bus.out_ready = ordy;
    endtask

    // Advance one clock; the model applies the architectural rules to the inputs present at the edge.
    task automatic tick();
        logic acc, pass, legal;
        acc   = bus.in_valid && (!m_ov || bus.out_ready);
        legal = (bus.in_cond == 4'b0000) || (bus.in_cond == 4'b0001) || (bus.in_cond == 4'b1110);
        pass  = (bus.in_cond == 4'b0000 && m_z) || (bus.in_cond == 4'b0001 && !m_z) ||
                (bus.in_cond == 4'b1110);
        @(posedge clk);
        #1;
        m_ill = acc && !legal;
        if (acc) begin
            m_ov  = 1;
            m_res = bus.in_result;
            m_rd  = bus.in_rd;
            m_rwe = pass && bus.in_reg_we;
            m_mwe = pass && bus.in_mem_we;
            m_pc  = pass && bus.in_pc_src;
            if (pass && bus.in_flag_upd) m_z = bus.in_zflag;
            if (!pass && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end else if (bus.out_ready) begin
            m_ov = 0; m_rwe = 0; m_mwe = 0; m_pc = 0;
        end
    endtask

    task automatic test_reset();
        logic [47:0] got;
        drive(0, 4'b1110, 0, 0, 0, 0, 0, 32'h0, 4'h0, 1);
        #2;
        got = {bus.out_valid, bus.out_result, bus.out_rd, bus.out_reg_we, bus.out_mem_we,
               bus.out_pc_src, z_flag, cond_illegal, squash_cnt};
        n_checks++;
        if (got !== 48'h0) begin
            n_fail++; $display("FAIL reset_initial: got %h expected 0", got);
        end
        @(negedge clk); rst_n = 1; model_reset();
        drive(1, 4'b1110, 1, 1, 1, 0, 0, 32'h1111_2222, 4'h3, 1); tick();
        drive(1, 4'b0001, 0, 0, 1, 1, 1, 32'h3333_4444, 4'h5, 1); tick();
        drive(0, 4'b1110, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0); tick();
        n_checks++;
        if ({bus.out_valid, z_flag, squash_cnt} !== {1'b1, 1'b1, 4'd1}) begin
            n_fail++; $display("FAIL reset_prestate: got %b expected 1_1_0001",
                               {bus.out_valid, z_flag, squash_cnt});
        end
        #2 rst_n = 0;
        #1;
        got = {bus.out_valid, bus.out_result, bus.out_rd, bus.out_reg_we, bus.out_mem_we,
               bus.out_pc_src, z_flag, cond_illegal, squash_cnt};
        n_checks++;
        if (got !== 48'h0) begin
            n_fail++; $display("FAIL reset_midstream: got %h expected 0", got);
        end
        @(negedge clk); rst_n = 1; model_reset();
    endtask

    task automatic test_cmp_beq();
        drive(1, 4'b1110, 1, 1, 0, 0, 0, 32'h0, 4'h0, 1); tick();
        n_checks++;
        if (z_flag !== 1'b1) begin
            n_fail++; $display("FAIL cmp_eq_zflag: got %b expected 1", z_flag);
        end
        drive(1, 4'b0000, 0, 0, 0, 0, 1, 32'h0000_0040, 4'hF, 1); tick();
        n_checks++;
        if ({bus.out_valid, bus.out_pc_src, squash_cnt} !== {1'b1, 1'b1, 4'd0}) begin
            n_fail++; $display("FAIL beq_taken: got %b expected 1_1_0000",
                               {bus.out_valid, bus.out_pc_src, squash_cnt});
        end
        drive(1, 4'b1110, 1, 0, 0, 0, 0, 32'h1, 4'h0, 1); tick();
        n_checks++;
        if (z_flag !== 1'b0) begin
            n_fail++; $display("FAIL cmp_ne_zflag: got %b expected 0", z_flag);
        end
        drive(1, 4'b0000, 0, 0, 0, 0, 1, 32'h0000_0040, 4'hF, 1); tick();
        n_checks++;
        if ({bus.out_valid, bus.out_pc_src, squash_cnt} !== {1'b1, 1'b0, 4'd1}) begin
            n_fail++; $display("FAIL beq_not_taken: got %b expected 1_0_0001",
                               {bus.out_valid, bus.out_pc_src, squash_cnt});
        end
        drive(0, 4'b1110, 0, 0, 0, 0, 0, 32'h0, 4'h0, 1); tick();
    endtask

    task automatic test_stall();
        drive(1, 4'b1110, 0, 0, 1, 0, 0, 32'hDEAD_BEEF, 4'h7, 0); tick();
        drive(1, 4'b1110, 1, 1, 1, 1, 0, 32'h1234_5678, 4'h9, 0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({bus.in_ready, bus.out_valid, bus.out_result, bus.out_rd, bus.out_reg_we, z_flag} !==
                {1'b0, 1'b1, 32'hDEAD_BEEF, 4'h7, 1'b1, m_z}) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got rdy=%b v=%b res=%h rd=%h we=%b z=%b",
                                   i, bus.in_ready, bus.out_valid, bus.out_result, bus.out_rd,
                                   bus.out_reg_we, z_flag);
            end
            tick();
        end
        bus.out_ready = 1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL stall_release_ready: got %b expected 1", bus.in_ready);
        end
        tick();
        n_checks++;
        if ({bus.out_valid, bus.out_result, bus.out_rd, bus.out_mem_we, z_flag} !==
            {1'b1, 32'h1234_5678, 4'h9, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL stall_replace: got v=%b res=%h rd=%h mwe=%b z=%b expected 1 12345678 9 1 1",
                               bus.out_valid, bus.out_result, bus.out_rd, bus.out_mem_we, z_flag);
        end
        drive(0, 4'b1110, 0, 0, 0, 0, 0, 32'h0, 4'h0, 1); tick();
        n_checks++;
        if ({bus.out_valid, bus.out_reg_we, bus.out_mem_we, bus.out_pc_src} !== 4'b0000) begin
            n_fail++; $display("FAIL stall_drain: got %b expected 0000",
                               {bus.out_valid, bus.out_reg_we, bus.out_mem_we, bus.out_pc_src});
        end
    endtask

    task automatic test_illegal();
        int cnt0;
        cnt0 = m_cnt;
        drive(1, 4'b1010, 0, 0, 1, 0, 0, 32'hA5A5_A5A5, 4'h2, 1); tick();
        n_checks++;
        if ({bus.out_valid, bus.out_reg_we, cond_illegal} !== 3'b101 || squash_cnt !== 4'(cnt0 + 1)) begin
            n_fail++; $display("FAIL illegal_cond: got v/we/ill=%b cnt=%0d expected 101 cnt=%0d",
                               {bus.out_valid, bus.out_reg_we, cond_illegal}, squash_cnt, cnt0 + 1);
        end
        drive(0, 4'b1110, 0, 0, 0, 0, 0, 32'h0, 4'h0, 1); tick();
        n_checks++;
        if (cond_illegal !== 1'b0) begin
            n_fail++; $display("FAIL illegal_pulse_width: got %b expected 0", cond_illegal);
        end
    endtask

    task automatic test_fail_no_update();
        drive(1, 4'b1110, 1, 0, 0, 0, 0, 32'h0, 4'h0, 1); tick();
        drive(1, 4'b0000, 1, 1, 1, 0, 0, 32'h5, 4'h1, 1); tick();
        n_checks++;
        if ({z_flag, bus.out_reg_we, bus.out_valid} !== 3'b001 || squash_cnt !== 4'(m_cnt)) begin
            n_fail++; $display("FAIL fail_no_zupdate: got z/we/v=%b cnt=%0d expected 001 cnt=%0d",
                               {z_flag, bus.out_reg_we, bus.out_valid}, squash_cnt, m_cnt);
        end
    endtask

    task automatic test_random();
        logic [3:0] cond;
        int sel;
        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 9));
            cond = (sel < 3) ? 4'b0000 : (sel < 6) ? 4'b0001 : (sel < 8) ? 4'b1110 : 4'($urandom);
            drive($urandom_range(0, 9) < 7, cond, 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 9) < 7);
            tick();
            n_checks++;
            if ({bus.out_valid, bus.out_reg_we, bus.out_mem_we, bus.out_pc_src, z_flag, cond_illegal,
                 squash_cnt, bus.in_ready} !==
                {m_ov, m_rwe, m_mwe, m_pc, m_z, m_ill, 4'(m_cnt), !m_ov || bus.out_ready}) begin
                n_fail++; $display("FAIL rand_ctrl[%0d]: got v%b we%b%b%b z%b il%b c%0d r%b expected v%b we%b%b%b z%b il%b c%0d",
                                   i, bus.out_valid, bus.out_reg_we, bus.out_mem_we, bus.out_pc_src,
                                   z_flag, cond_illegal, squash_cnt, bus.in_ready,
                                   m_ov, m_rwe, m_mwe, m_pc, m_z, m_ill, m_cnt);
            end
            if (m_ov) begin
                n_checks++;
                if ({bus.out_result, bus.out_rd} !== {m_res, m_rd}) begin
                    n_fail++; $display("FAIL rand_data[%0d]: got %h/%h expected %h/%h",
                                       i, bus.out_result, bus.out_rd, m_res, m_rd);
                end
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            drive(1, 4'b0011, 0, 0, 1, 1, 1, 32'(i), 4'h0, 1); tick();
        end
        n_checks++;
        if (squash_cnt !== 4'hF || m_cnt != 15) begin
            n_fail++; $display("FAIL sat_reach: got %h expected F", squash_cnt);
        end
        drive(1, 4'b0100, 0, 0, 0, 0, 0, 32'h0, 4'h0, 1); tick(); tick();
        n_checks++;
        if (squash_cnt !== 4'hF) begin
            n_fail++; $display("FAIL sat_hold: got %h expected F", squash_cnt);
        end
        drive(0, 4'b1110, 0, 0, 0, 0, 0, 32'h0, 4'h0, 1); tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_cmp_beq();
        test_stall();
        test_illegal();
        test_fail_no_update();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
